vga_mem_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM (sprite/arrow tile store) between three requesters:
  - the display fetch path, driven by the 640x480 timing generator's pixel x/y;
  - writer 0, the step-pattern loader;
  - writer 1, the score/HUD updater.
- Display reads have absolute priority.
- Writes are granted only inside a write window. The window opens on the timing generator's end-of-frame `animate` pulse and lasts a fixed number of clocks.
- Sits between the VGA timing block, the game logic and the RAM macro.

---
 rtl/vga_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port synchronous video RAM between the display fetch path
// (absolute priority) and two writers that may only write inside a per-frame window.
module vga_mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 8,
  parameter int WIN_CYC   = 20000,
  parameter int MAX_BURST = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_animate,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic [DW-1:0] o_disp_data,
  output logic          o_disp_valid,
  input  logic          i_wr0_req,
  input  logic [AW-1:0] i_wr0_addr,
  input  logic [DW-1:0] i_wr0_data,
  output logic          o_wr0_ack,
  input  logic          i_wr1_req,
  input  logic [AW-1:0] i_wr1_addr,
  input  logic [DW-1:0] i_wr1_data,
  output logic          o_wr1_ack,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_win_open,
  output logic          o_overrun
);

  localparam int CW = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WIN_CYC - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rr_ptr;     // writer preferred when nobody holds the grant
  logic [BW-1:0] r_burst_cnt;  // 0 only until the first write grant after reset
  logic          r_rd_stage;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_close;
  logic          w_any_wr;
  logic          w_rd_grant;
  logic          w_wr_grant;
  logic          w_wr_sel;
  logic          w_holder;
  logic          w_has_holder;
  logic          w_rr_ptr_next;
  logic [BW-1:0] w_burst_next;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_close      = 1'b0;
    case (r_state)
      ST_CLOSED: begin
        if (i_animate) begin
          w_state_next = ST_OPEN;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ST_OPEN: begin
        // A new frame pulse always extends the window, even on its last cycle.
        if (i_animate) begin
          w_cnt_next = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_next = ST_CLOSED;
          w_close      = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = ST_CLOSED;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_any_wr     = i_wr0_req | i_wr1_req;
    w_rd_grant   = i_disp_req;
    w_wr_grant   = (r_state == ST_OPEN) && !i_disp_req && w_any_wr;
    w_holder     = ~r_rr_ptr;
    w_has_holder = (r_burst_cnt != '0);

    w_wr_sel = r_rr_ptr;
    if (i_wr0_req && !i_wr1_req) begin
      w_wr_sel = 1'b0;
    end else if (!i_wr0_req && i_wr1_req) begin
      w_wr_sel = 1'b1;
    end else if (w_has_holder && (r_burst_cnt < BURST_MAX)) begin
      w_wr_sel = w_holder;
    end

    w_rr_ptr_next = r_rr_ptr;
    w_burst_next  = r_burst_cnt;
    if (w_wr_grant) begin
      w_rr_ptr_next = ~w_wr_sel;
      if (w_has_holder && (w_wr_sel == w_holder)) begin
        // A lone requester may exceed the burst limit; saturate so the count stays meaningful.
        w_burst_next = (r_burst_cnt < BURST_MAX) ? r_burst_cnt + BW'(1) : r_burst_cnt;
      end else begin
        w_burst_next = BW'(1);
      end
    end

    w_wr_addr = w_wr_sel ? i_wr1_addr : i_wr0_addr;
    w_wr_data = w_wr_sel ? i_wr1_data : i_wr0_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_CLOSED;
      r_cnt        <= '0;
      r_rr_ptr     <= 1'b0;
      r_burst_cnt  <= '0;
      r_rd_stage   <= 1'b0;
      o_disp_data  <= '0;
      o_disp_valid <= 1'b0;
      o_wr0_ack    <= 1'b0;
      o_wr1_ack    <= 1'b0;
      o_mem_en     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_burst_cnt <= w_burst_next;

      o_mem_en <= w_rd_grant | w_wr_grant;
      o_mem_we <= w_wr_grant;
      if (w_rd_grant) begin
        o_mem_addr <= i_disp_addr;
      end else if (w_wr_grant) begin
        o_mem_addr  <= w_wr_addr;
        o_mem_wdata <= w_wr_data;
      end

      o_wr0_ack <= w_wr_grant & ~w_wr_sel;
      o_wr1_ack <= w_wr_grant & w_wr_sel;

      // RAM returns data the cycle after the enable; capture it one edge later.
      r_rd_stage   <= o_mem_en & ~o_mem_we;
      o_disp_valid <= r_rd_stage;
      if (r_rd_stage) begin
        o_disp_data <= i_mem_rdata;
      end

      o_overrun <= w_close & w_any_wr;
    end
  end

  assign o_win_open = (r_state == ST_OPEN);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: a behavioural RAM on the memory port,
// expected reads/writes queued at stimulus time and compared when the DUT responds.
module tb_vga_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          animate;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr0_req;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr0_ack;
  logic          wr1_req;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          wr1_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          win_open;
  logic          overrun;

  typedef struct packed {
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] rd_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            n_vec;
  int            n_err;
  int            n_valid;
  int            n_ovr;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .WIN_CYC(8), .MAX_BURST(4)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_animate(animate),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_data(disp_data), .o_disp_valid(disp_valid),
    .i_wr0_req(wr0_req), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data), .o_wr0_ack(wr0_ack),
    .i_wr1_req(wr1_req), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data), .o_wr1_ack(wr1_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_win_open(win_open), .o_overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3 ^ {4'h0, a[11:8]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, disp_data, disp_valid, wr0_ack, wr1_ack, mem_en, mem_we,
            mem_addr, mem_wdata, win_open, overrun};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) n_ovr++;
      if (disp_valid) begin
        n_valid++;
        if (rd_q.size() == 0) begin
          check_val("rd_unexpected", {56'd0, disp_data}, 64'hFFFF);
        end else begin
          logic [DW-1:0] e;
          e = rd_q.pop_front();
          $display("read  data=%02h want=%02h", disp_data, e);
          check_val("rd_data", {56'd0, disp_data}, {56'd0, e});
        end
      end
      if (wr0_ack || wr1_ack || (mem_en && mem_we)) begin
        if (wr_q.size() == 0) begin
          check_val("wr_unexpected", {61'd0, wr1_ack, wr0_ack, mem_we}, 64'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          $display("write wr%0d addr=%03h data=%02h", wr1_ack, mem_addr, mem_wdata);
          check_val("wr_grant", {41'd0, wr1_ack, wr0_ack, mem_we, mem_addr, mem_wdata},
                    {41'd0, w.id, ~w.id, 1'b1, w.addr, w.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] prio_addr [3];
    int            base_valid;
    n_vec = 0; n_err = 0; n_valid = 0; n_ovr = 0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));
    ram[12'h123] = 8'h5A;
    mem_rdata = '0;
    rst_n = 1'b0; animate = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    repeat (3) tick();
    check_val("rst_outs", all_outs(), 64'd0);

    // Reset arriving while a read is in flight.
    rst_n = 1'b1;
    tick();
    disp_req = 1'b1; disp_addr = 12'h055;
    tick();
    disp_req = 1'b0;
    check_val("rst_rd_issue", {63'd0, mem_en}, 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_val("rst_async", all_outs(), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_val("rst_no_valid", 64'(n_valid), 64'd0);
    check_val("rst_idle", all_outs(), 64'd0);

    // Read latency with the window closed.
    disp_req = 1'b1; disp_addr = 12'h123;
    rd_q.push_back(8'h5A);
    tick();
    disp_req = 1'b0;
    check_val("rd_issue", {50'd0, mem_en, mem_we, mem_addr}, {50'd0, 1'b1, 1'b0, 12'h123});
    tick();
    check_val("rd_lat1", {63'd0, disp_valid}, 64'd0);
    tick();
    check_val("rd_lat2", {55'd0, disp_valid, disp_data}, {55'd0, 1'b1, 8'h5A});
    tick();
    check_val("idle_hold", {51'd0, mem_en, mem_addr}, {51'd0, 1'b0, 12'h123});

    // Back-to-back reads.
    base_valid = n_valid;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = AW'(12'h300 + i);
      rd_q.push_back(pat(AW'(12'h300 + i)));
      tick();
    end
    disp_req = 1'b0;
    repeat (3) tick();
    check_val("rd_pipe", 64'(n_valid - base_valid), 64'd4);

    // Window gating.
    wr0_req = 1'b1; wr0_addr = 12'h010; wr0_data = 8'hA5;
    repeat (4) tick();
    check_val("gate_closed", {60'd0, wr0_ack, wr1_ack, mem_en, win_open}, 64'd0);
    animate = 1'b1;
    tick();
    animate = 1'b0;
    check_val("gate_open", {62'd0, win_open, wr0_ack}, {62'd0, 2'b10});
    wr_q.push_back('{id: 1'b0, addr: 12'h010, data: 8'hA5});
    tick();
    check_val("gate_ack", {42'd0, wr0_ack, mem_we, mem_addr, mem_wdata},
              {42'd0, 1'b1, 1'b1, 12'h010, 8'hA5});
    wr0_req = 1'b0;
    tick();
    check_val("ack_single", {63'd0, wr0_ack}, 64'd0);
    repeat (8) tick();
    check_val("gate_closed2", {63'd0, win_open}, 64'd0);

    // Display priority inside the window.
    prio_addr[0] = 12'h010; prio_addr[1] = 12'h201; prio_addr[2] = 12'h202;
    animate = 1'b1;
    tick();
    animate = 1'b0;
    wr0_req = 1'b1; wr0_addr = 12'h020; wr0_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = prio_addr[i];
      rd_q.push_back((i == 0) ? 8'hA5 : pat(prio_addr[i]));
      tick();
      check_val("prio_rd", {61'd0, mem_en, mem_we, wr0_ack}, {61'd0, 3'b100});
    end
    disp_req = 1'b0;
    wr_q.push_back('{id: 1'b0, addr: 12'h020, data: 8'h11});
    tick();
    check_val("prio_wr", {50'd0, wr0_ack, mem_we, mem_addr}, {50'd0, 1'b1, 1'b1, 12'h020});
    wr0_req = 1'b0;
    repeat (8) tick();
    check_val("prio_drain", 64'(rd_q.size()), 64'd0);

    // Round-robin bursts from a fresh reset, with a mid-window reload.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr0_req = 1'b1; wr0_addr = 12'h030; wr0_data = 8'h30;
    wr1_req = 1'b1; wr1_addr = 12'h031; wr1_data = 8'h31;
    animate = 1'b1;
    tick();
    for (int g = 1; g <= 10; g++) begin
      logic id;
      id = (((g - 1) / 4) % 2) == 1;
      wr_q.push_back(id ? wr_t'({1'b1, 12'h031, 8'h31}) : wr_t'({1'b0, 12'h030, 8'h30}));
      animate = (g == 5);
      tick();
      check_val("rr_ack", {62'd0, wr1_ack, wr0_ack}, id ? 64'd2 : 64'd1);
    end
    animate = 1'b0;
    wr0_req = 1'b0; wr1_req = 1'b0;
    tick();
    check_val("rr_stop", {62'd0, wr1_ack, wr0_ack}, 64'd0);
    repeat (6) tick();
    check_val("rr_closed", {63'd0, win_open}, 64'd0);
    check_val("rr_no_ovr", 64'(n_ovr), 64'd0);

    // Window end with writer 1 still requesting.
    wr1_req = 1'b1; wr1_addr = 12'h040; wr1_data = 8'h44;
    animate = 1'b1;
    tick();
    animate = 1'b0;
    for (int g = 1; g <= 8; g++) begin
      wr_q.push_back('{id: 1'b1, addr: 12'h040, data: 8'h44});
      tick();
      check_val("end_ack", {63'd0, wr1_ack}, 64'd1);
    end
    check_val("end_close", {61'd0, win_open, wr1_ack, overrun}, {61'd0, 3'b011});
    tick();
    check_val("end_after", {61'd0, win_open, wr1_ack, overrun}, 64'd0);
    wr1_req = 1'b0;
    tick();
    check_val("ovr_once", 64'(n_ovr), 64'd1);

    // animate coinciding with the last open cycle keeps the window open.
    animate = 1'b1;
    tick();
    animate = 1'b0;
    repeat (7) tick();
    check_val("coinc_pre", {63'd0, win_open}, 64'd1);
    animate = 1'b1;
    tick();
    animate = 1'b0;
    check_val("coinc_open", {62'd0, win_open, overrun}, {62'd0, 2'b10});
    repeat (7) tick();
    check_val("coinc_last", {63'd0, win_open}, 64'd1);
    tick();
    check_val("coinc_close", {63'd0, win_open}, 64'd0);
    tick();
    check_val("coinc_no_ovr", 64'(n_ovr), 64'd1);
    check_val("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check_val("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
